// File: rtl/booth_pkg.sv
// Shared types and sizing for the radix-2 Booth multiplier.
// Holds the FSM state encoding, the default operand width and the step-counter width.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

  // The counter must hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract M on {Q[0],Q_1}, then arithmetic shift of {A,Q,Q_1}.
// Purely combinational, zero latency, no flow control.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   a_nxt,
  output logic [WIDTH-1:0] q_nxt,
  output logic             q_1_nxt
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = a;
    unique case ({q[0], q_1})
      2'b01:   sum = a + m;
      2'b10:   sum = a - m;
      default: sum = a;
    endcase
  end

  // A is one bit wider than the operands, so its MSB is the true sign to replicate.
  assign a_nxt   = {sum[WIDTH], sum[WIDTH:1]};
  assign q_nxt   = {sum[0], q[WIDTH-1:1]};
  assign q_1_nxt = q[0];

endmodule

// File: rtl/booth_mul.sv
// Sequential signed Booth multiplier, one step per clock; result WIDTH+1 cycles after start.
// No backpressure: start is only honoured in IDLE, valid is a single-cycle pulse.
module booth_mul
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     X,
  input  logic [WIDTH-1:0]     Y,
  output logic                 valid,
  output logic [2*WIDTH-1:0]   Z
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH:0]   a;
  logic [WIDTH:0]   m;
  logic [WIDTH-1:0] q;
  logic             q_1;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   a_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             q_1_nxt;

  booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a       (a),
    .q       (q),
    .q_1     (q_1),
    .m       (m),
    .a_nxt   (a_nxt),
    .q_nxt   (q_nxt),
    .q_1_nxt (q_1_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      valid <= 1'b0;
      Z     <= '0;
      a     <= '0;
      m     <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      count <= '0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            m     <= {X[WIDTH-1], X};
            q     <= Y;
            a     <= '0;
            q_1   <= 1'b0;
            count <= CW'(WIDTH);
            state <= BUSY;
          end
        end
        BUSY: begin
          a     <= a_nxt;
          q     <= q_nxt;
          q_1   <= q_1_nxt;
          count <= count - CW'(1);
          if (count == CW'(1)) state <= DONE;
        end
        DONE: begin
          // The product fits in 2*WIDTH bits, so the extra sign bit of A is dropped.
          Z     <= {a[WIDTH-1:0], q};
          valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul.sv
// Self-checking bench for booth_mul: vector table, corner-case sequences and random pairs via a scoreboard.
module tb_booth_mul;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  X = '0;
  logic [7:0]  Y = '0;
  logic        valid;
  logic [15:0] Z;

  int errors = 0;
  int checks = 0;
  logic [15:0] sb[$];
  logic prev_valid = 1'b0;
  int pulses = 0;

  typedef struct {
    logic signed [7:0]  x;
    logic signed [7:0]  y;
    logic signed [15:0] z;
  } vec_t;

  always #5 clk = ~clk;

  booth_mul #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .X     (X),
    .Y     (Y),
    .valid (valid),
    .Z     (Z)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  // Scoreboard side: every valid pulse must be one cycle wide and match the oldest expectation.
  always @(negedge clk) begin
    if (valid) begin
      pulses++;
      check("valid_width", {31'd0, prev_valid}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got Z=%0d with no pending operation", $signed(Z));
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        check("product", {16'd0, Z}, {16'd0, e});
      end
    end
    prev_valid = valid;
  end

  // Launch one operation with a one-cycle start pulse and check the result latency.
  task automatic run_op(input logic signed [7:0] x, input logic signed [7:0] y,
                        input logic signed [15:0] exp);
    int cyc;
    @(negedge clk);
    X = x;
    Y = y;
    start = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!valid && cyc < 30);
    check("latency", cyc, 9);
    @(negedge clk);
    check("valid_low_after", {31'd0, valid}, 32'd0);
  endtask

  task automatic wait_idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vec_t tbl[7];
    tbl[0] = '{x: 8'sd62,   y: 8'sd37,   z: 16'sd2294};
    tbl[1] = '{x: 8'sd34,   y: -8'sd9,   z: -16'sd306};
    tbl[2] = '{x: -8'sd18,  y: -8'sd10,  z: 16'sd180};
    tbl[3] = '{x: 8'sd0,    y: 8'sd12,   z: 16'sd0};
    tbl[4] = '{x: -8'sd128, y: -8'sd128, z: 16'sd16384};
    tbl[5] = '{x: 8'sd127,  y: -8'sd128, z: -16'sd16256};
    tbl[6] = '{x: -8'sd1,   y: 8'sd1,    z: -16'sd1};

    #2;
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_z", {16'd0, Z}, 32'd0);
    #8;
    rst = 1'b1;

    for (int i = 0; i < 7; i++) run_op(tbl[i].x, tbl[i].y, tbl[i].z);

    // start held for 3 cycles, operands disturbed while busy: one product from the first operands.
    pulses = 0;
    @(negedge clk);
    X = 8'sd25;
    Y = -8'sd7;
    start = 1'b1;
    sb.push_back(-16'sd175);
    @(negedge clk);
    X = 8'sd100;
    Y = 8'sd100;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    X = -8'sd3;
    Y = 8'sd55;
    wait_idle(20);
    check("held_start_pulses", pulses, 1);

    // start held high across completion: back-to-back operations, each with its own pulse.
    pulses = 0;
    @(negedge clk);
    X = -8'sd11;
    Y = 8'sd13;
    start = 1'b1;
    sb.push_back(-16'sd143);
    sb.push_back(-16'sd143);
    repeat (12) @(negedge clk);
    start = 1'b0;
    wait_idle(20);
    check("b2b_pulses", pulses, 2);

    // Reset mid-operation clears outputs at once and the aborted op never reports.
    @(negedge clk);
    X = 8'sd9;
    Y = 8'sd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(4);
    #1;
    rst = 1'b0;
    #1;
    check("abort_valid", {31'd0, valid}, 32'd0);
    check("abort_z", {16'd0, Z}, 32'd0);
    wait_idle(2);
    rst = 1'b1;
    pulses = 0;
    wait_idle(12);
    check("abort_no_pulse", pulses, 0);
    run_op(8'sd9, -8'sd9, -16'sd81);

    for (int i = 0; i < 40; i++) begin
      logic signed [7:0]  rx;
      logic signed [7:0]  ry;
      logic signed [15:0] rz;
      rx = 8'($urandom);
      ry = 8'($urandom);
      rz = rx * ry;
      run_op(rx, ry, rz);
    end

    wait_idle(5);
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
